// File: rtl/unidade_controle_if.sv
// Control/condition bundle between unidade_controle and the fluxo_dados datapath.
// The controller side (master) drives every datapath control and the game flags;
// the datapath/top-level side (slave) drives the condition signals and iniciar.
interface unidade_controle_if;
   // requests and datapath conditions
   logic       iniciar;
   logic       jogada_feita;
   logic       jogada_correta;
   logic       enderecoIgualRodada;
   logic       fimCR;
   logic       fimTF;
   logic       fimTempo;

   // datapath controls
   logic       zeraR;
   logic       registraR;
   logic       zeraC;
   logic       contaC;
   logic       zeraCR;
   logic       contaCR;
   logic       zeraTempo;
   logic       contaTempo;
   logic       zeraTM;
   logic       contaTM;
   logic       ativa_leds_mem;
   logic       ativa_leds_jog;
   logic       toca;
   logic       gravaM;

   // game status
   logic       pronto;
   logic       ganhou;
   logic       perdeu;
   logic       timeout;
   logic [4:0] db_estado;

   modport master (
      input  iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
             fimCR, fimTF, fimTempo,
      output zeraR, registraR, zeraC, contaC, zeraCR, contaCR,
             zeraTempo, contaTempo, zeraTM, contaTM,
             ativa_leds_mem, ativa_leds_jog, toca, gravaM,
             pronto, ganhou, perdeu, timeout, db_estado
   );

   modport slave (
      output iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
             fimCR, fimTF, fimTempo,
      input  zeraR, registraR, zeraC, contaC, zeraCR, contaCR,
             zeraTempo, contaTempo, zeraTM, contaTM,
             ativa_leds_mem, ativa_leds_jog, toca, gravaM,
             pronto, ganhou, perdeu, timeout, db_estado
   );
endinterface

// File: rtl/unidade_controle.sv
// Moore sequencer for the "follow-me" piano game. Each round replays the
// stored notes up to the current round, then checks the player's notes one
// by one with a per-note timeout; optionally appends one new player note.
//
// state                 | meaning
// ----------------------+----------------------------------------------------
// 00h INICIAL           | idle, waiting for iniciar
// 01h PREPARACAO        | clear play register, counters and timers
// 02h MOSTRA            | show/play memory note at current address
// 03h AVALIA_MOSTRA     | last note of this round shown?
// 04h INCREMENTA_MOSTRA | advance to next note to show
// 05h INICIA_JOGADA     | rewind address, restart timers for the player
// 06h ESPERA_JOGADA     | wait for a press, 5 s timeout running
// 07h REGISTRA          | capture the pressed note
// 08h FEEDBACK          | echo the pressed note on LEDs/buzzer
// 09h COMPARA           | judge the note against memory
// 0Ah PROXIMA_JOGADA    | next note of the same round
// 0Bh PROXIMA_RODADA    | round won, advance round counter
// 0Ch GANHOU            | game won (held until iniciar)
// 0Dh ERROU             | wrong note (held until iniciar)
// 0Eh TIMEOUT           | no press in time (held until iniciar)
// 10h ESPERA_NOVA       | wait for the new note to append
// 11h REINICIA_MOSTRA   | rewind for the next replay
// 12h GRAVA             | write the new note into memory
// 13h FEEDBACK_NOVA     | echo the new note
module unidade_controle #(
   parameter bit GRAVA_NOVA = 1'b1
) (
   input logic               clock,
   input logic               reset,
   unidade_controle_if.master ctrl
);

   typedef enum logic [4:0] {
      INICIAL           = 5'h00,
      PREPARACAO        = 5'h01,
      MOSTRA            = 5'h02,
      AVALIA_MOSTRA     = 5'h03,
      INCREMENTA_MOSTRA = 5'h04,
      INICIA_JOGADA     = 5'h05,
      ESPERA_JOGADA     = 5'h06,
      REGISTRA          = 5'h07,
      FEEDBACK          = 5'h08,
      COMPARA           = 5'h09,
      PROXIMA_JOGADA    = 5'h0A,
      PROXIMA_RODADA    = 5'h0B,
      FIM_GANHOU        = 5'h0C,
      FIM_ERROU         = 5'h0D,
      FIM_TIMEOUT       = 5'h0E,
      ESPERA_NOVA       = 5'h10,
      REINICIA_MOSTRA   = 5'h11,
      GRAVA             = 5'h12,
      FEEDBACK_NOVA     = 5'h13
   } estadoT;

   estadoT estadoAtual;
   estadoT proximoEstado;

   // state register, asynchronous active-low reset back to idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estadoAtual <= INICIAL;
      end else begin
         estadoAtual <= proximoEstado;
      end
   end

   // next-state logic and Moore output decode
   always_comb begin
      proximoEstado       = estadoAtual;
      ctrl.zeraR          = 1'b0;
      ctrl.registraR      = 1'b0;
      ctrl.zeraC          = 1'b0;
      ctrl.contaC         = 1'b0;
      ctrl.zeraCR         = 1'b0;
      ctrl.contaCR        = 1'b0;
      ctrl.zeraTempo      = 1'b0;
      ctrl.contaTempo     = 1'b0;
      ctrl.zeraTM         = 1'b0;
      ctrl.contaTM        = 1'b0;
      ctrl.ativa_leds_mem = 1'b0;
      ctrl.ativa_leds_jog = 1'b0;
      ctrl.toca           = 1'b0;
      ctrl.gravaM         = 1'b0;
      ctrl.pronto         = 1'b0;
      ctrl.ganhou         = 1'b0;
      ctrl.perdeu         = 1'b0;
      ctrl.timeout        = 1'b0;

      case (estadoAtual)
         INICIAL: begin
            if (ctrl.iniciar) begin
               proximoEstado = PREPARACAO;
            end
         end

         PREPARACAO: begin
            ctrl.zeraR     = 1'b1;
            ctrl.zeraC     = 1'b1;
            ctrl.zeraCR    = 1'b1;
            ctrl.zeraTempo = 1'b1;
            ctrl.zeraTM    = 1'b1;
            proximoEstado  = MOSTRA;
         end

         MOSTRA: begin
            ctrl.ativa_leds_mem = 1'b1;
            ctrl.toca           = 1'b1;
            ctrl.contaTM        = 1'b1;
            if (ctrl.fimTF) begin
               proximoEstado = AVALIA_MOSTRA;
            end
         end

         AVALIA_MOSTRA: begin
            ctrl.zeraTM = 1'b1;
            if (ctrl.enderecoIgualRodada) begin
               proximoEstado = INICIA_JOGADA;
            end else begin
               proximoEstado = INCREMENTA_MOSTRA;
            end
         end

         INCREMENTA_MOSTRA: begin
            ctrl.contaC   = 1'b1;
            proximoEstado = MOSTRA;
         end

         INICIA_JOGADA: begin
            ctrl.zeraC     = 1'b1;
            ctrl.zeraTempo = 1'b1;
            ctrl.zeraTM    = 1'b1;
            proximoEstado  = ESPERA_JOGADA;
         end

         // a press in the same cycle as the timeout still counts as a play
         ESPERA_JOGADA: begin
            ctrl.contaTempo = 1'b1;
            if (ctrl.jogada_feita) begin
               proximoEstado = REGISTRA;
            end else if (ctrl.fimTempo) begin
               proximoEstado = FIM_TIMEOUT;
            end
         end

         REGISTRA: begin
            ctrl.registraR = 1'b1;
            proximoEstado  = FEEDBACK;
         end

         FEEDBACK: begin
            ctrl.ativa_leds_jog = 1'b1;
            ctrl.toca           = 1'b1;
            ctrl.contaTM        = 1'b1;
            if (ctrl.fimTF) begin
               proximoEstado = COMPARA;
            end
         end

         // a wrong note loses even on the last note of the last round
         COMPARA: begin
            ctrl.zeraTM = 1'b1;
            if (!ctrl.jogada_correta) begin
               proximoEstado = FIM_ERROU;
            end else if (!ctrl.enderecoIgualRodada) begin
               proximoEstado = PROXIMA_JOGADA;
            end else if (ctrl.fimCR) begin
               proximoEstado = FIM_GANHOU;
            end else begin
               proximoEstado = PROXIMA_RODADA;
            end
         end

         PROXIMA_JOGADA: begin
            ctrl.contaC    = 1'b1;
            ctrl.zeraTempo = 1'b1;
            proximoEstado  = ESPERA_JOGADA;
         end

         // address steps with the round so the new note lands at index round+1
         PROXIMA_RODADA: begin
            ctrl.contaCR   = 1'b1;
            ctrl.contaC    = 1'b1;
            ctrl.zeraTempo = 1'b1;
            if (GRAVA_NOVA) begin
               proximoEstado = ESPERA_NOVA;
            end else begin
               proximoEstado = REINICIA_MOSTRA;
            end
         end

         ESPERA_NOVA: begin
            ctrl.contaTempo = 1'b1;
            if (ctrl.jogada_feita) begin
               proximoEstado = GRAVA;
            end else if (ctrl.fimTempo) begin
               proximoEstado = FIM_TIMEOUT;
            end
         end

         GRAVA: begin
            ctrl.registraR = 1'b1;
            ctrl.gravaM    = 1'b1;
            proximoEstado  = FEEDBACK_NOVA;
         end

         FEEDBACK_NOVA: begin
            ctrl.ativa_leds_jog = 1'b1;
            ctrl.toca           = 1'b1;
            ctrl.contaTM        = 1'b1;
            if (ctrl.fimTF) begin
               proximoEstado = REINICIA_MOSTRA;
            end
         end

         REINICIA_MOSTRA: begin
            ctrl.zeraC     = 1'b1;
            ctrl.zeraTM    = 1'b1;
            ctrl.zeraTempo = 1'b1;
            proximoEstado  = MOSTRA;
         end

         FIM_GANHOU: begin
            ctrl.pronto = 1'b1;
            ctrl.ganhou = 1'b1;
            if (ctrl.iniciar) begin
               proximoEstado = PREPARACAO;
            end
         end

         FIM_ERROU: begin
            ctrl.pronto = 1'b1;
            ctrl.perdeu = 1'b1;
            if (ctrl.iniciar) begin
               proximoEstado = PREPARACAO;
            end
         end

         FIM_TIMEOUT: begin
            ctrl.pronto  = 1'b1;
            ctrl.perdeu  = 1'b1;
            ctrl.timeout = 1'b1;
            if (ctrl.iniciar) begin
               proximoEstado = PREPARACAO;
            end
         end

         default: begin
            proximoEstado = INICIAL;
         end
      endcase
   end

   assign ctrl.db_estado = estadoAtual;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: a behavioural fluxo_dados (counters, memory,
// timers) closes the loop, a player process presses buttons from a planned
// game, and a monitor compares observed shows/results against a queue of
// expectations derived from the game rules.
module tb_unidade_controle;

   localparam int TF     = 3;
   localparam int TO     = 12;
   localparam int BUDGET = 5000;

   localparam logic [17:0] VEC_PREP   = 18'b101010101000000000;
   localparam logic [17:0] VEC_MOSTRA = 18'b000000000110100000;

   typedef struct {
      bit         ehTimeout;
      int         atraso;
      logic [3:0] nota;
   } jogada_t;

   typedef struct {
      logic [2:0] codigo;
      logic [4:0] estado;
      int         mostras;
      int         gravas;
   } resultado_t;

   logic        clock;
   logic        reset;
   logic [3:0]  botoes;
   logic [3:0]  nota0;
   logic [3:0]  limite;
   logic [3:0]  dpMem [0:15];
   logic [3:0]  dpC, dpCR, dpR;
   logic [7:0]  dpTM, dpTempo;
   logic [17:0] ctrlVec;

   int checks = 0;
   int errors = 0;

   jogada_t    filaJogadas[$];
   resultado_t filaResultados[$];
   logic [3:0] filaMostra[$];

   unidade_controle_if ifc ();

   unidade_controle #(.GRAVA_NOVA(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .ctrl  (ifc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [3:0] notaEm(input logic [3:0] a);
      return (a == 4'd0) ? nota0 : dpMem[a];
   endfunction

   // behavioural datapath; end-of-game round is chosen per game to keep games short
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         dpC     <= '0;
         dpCR    <= '0;
         dpR     <= '0;
         dpTM    <= '0;
         dpTempo <= '0;
      end else begin
         if (ifc.zeraC) dpC <= '0;
         else if (ifc.contaC) dpC <= dpC + 4'd1;
         if (ifc.zeraCR) dpCR <= '0;
         else if (ifc.contaCR) dpCR <= dpCR + 4'd1;
         if (ifc.zeraR) dpR <= '0;
         else if (ifc.registraR) dpR <= botoes;
         if (ifc.zeraTM) dpTM <= '0;
         else if (ifc.contaTM) dpTM <= dpTM + 8'd1;
         if (ifc.zeraTempo) dpTempo <= '0;
         else if (ifc.contaTempo) dpTempo <= dpTempo + 8'd1;
         if (ifc.gravaM) dpMem[dpC] <= botoes;
      end
   end

   assign ifc.jogada_correta      = (notaEm(dpC) == dpR);
   assign ifc.enderecoIgualRodada = (dpC == dpCR);
   assign ifc.fimCR               = (dpCR == limite);
   assign ifc.fimTF               = (dpTM == 8'(TF - 1));
   assign ifc.fimTempo            = (dpTempo == 8'(TO - 1));

   assign ctrlVec = {ifc.zeraR, ifc.registraR, ifc.zeraC, ifc.contaC, ifc.zeraCR,
                     ifc.contaCR, ifc.zeraTempo, ifc.contaTempo, ifc.zeraTM, ifc.contaTM,
                     ifc.ativa_leds_mem, ifc.ativa_leds_jog, ifc.toca, ifc.gravaM,
                     ifc.pronto, ifc.ganhou, ifc.perdeu, ifc.timeout};

   task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      checks++;
      if (atual !== esperado) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
      end
   endtask

   task automatic falha(input string nome);
      checks++;
      errors++;
      $display("FAIL %s: got nothing expected an event at %0t", nome, $time);
   endtask

   task automatic limpaFilas();
      filaJogadas.delete();
      filaResultados.delete();
      filaMostra.delete();
   endtask

   task automatic aplicaReset();
      reset = 1'b0;
      limpaFilas();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   // reference model: from a random song and player behaviour, derive the notes
   // that must be shown, the plays to make, and the game outcome
   task automatic planGame(input int modo, output logic [2:0] codigo, output logic [4:0] estado);
      logic [3:0] seq [0:15];
      int         lim, mostras, gravas, sorteio;
      bit         fim;
      jogada_t    p;
      resultado_t res;
      if (modo == 4) lim = 0;
      else if (modo == 3) lim = int'($urandom_range(1, 3));
      else lim = int'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) seq[k] = 4'($urandom);
      nota0   = seq[0];
      limite  = 4'(lim);
      mostras = 0;
      gravas  = 0;
      fim     = 1'b0;
      codigo  = 3'b000;
      estado  = 5'h00;
      for (int r = 0; r <= lim && !fim; r++) begin
         for (int j = 0; j <= r; j++) filaMostra.push_back(seq[j]);
         mostras += r + 1;
         for (int j = 0; j <= r && !fim; j++) begin
            sorteio     = int'($urandom_range(0, 39));
            p.ehTimeout = 1'b0;
            p.nota      = seq[j];
            p.atraso    = (modo == 2 || $urandom_range(0, 5) == 0) ? TO - 1 : int'($urandom_range(0, 4));
            if (modo == 1 || (modo == 0 && sorteio == 0)) begin
               p.ehTimeout = 1'b1;
               codigo = 3'b011; estado = 5'h0E; fim = 1'b1;
            end else if ((modo == 3 && r == 1 && j == 1) || (modo == 0 && sorteio == 1)) begin
               p.nota = seq[j] ^ 4'($urandom_range(1, 15));
               codigo = 3'b010; estado = 5'h0D; fim = 1'b1;
            end
            filaJogadas.push_back(p);
         end
         if (!fim && r == lim) begin
            codigo = 3'b100; estado = 5'h0C; fim = 1'b1;
         end else if (!fim) begin
            p.ehTimeout = 1'b0;
            p.nota      = seq[r + 1];
            p.atraso    = (modo == 2) ? TO - 1 : int'($urandom_range(0, 4));
            if (modo == 0 && $urandom_range(0, 39) == 0) begin
               p.ehTimeout = 1'b1;
               codigo = 3'b011; estado = 5'h0E; fim = 1'b1;
            end else begin
               gravas++;
            end
            filaJogadas.push_back(p);
         end
      end
      res.codigo  = codigo;
      res.estado  = estado;
      res.mostras = mostras;
      res.gravas  = gravas;
      filaResultados.push_back(res);
   endtask

   task automatic iniciaPartida();
      @(negedge clock);
      ifc.iniciar = 1'b1;
      @(negedge clock);
      ifc.iniciar = 1'b0;
      verifica("estado_preparacao", 32'(ifc.db_estado), 32'h01);
      verifica("saidas_preparacao", 32'(ctrlVec), 32'(VEC_PREP));
      @(negedge clock);
      verifica("estado_mostra", 32'(ifc.db_estado), 32'h02);
      verifica("saidas_mostra", 32'(ctrlVec), 32'(VEC_MOSTRA));
   endtask

   task automatic jogarPartida(input int modo);
      logic [2:0] codigo;
      logic [4:0] estado;
      int n;
      planGame(modo, codigo, estado);
      iniciaPartida();
      n = 0;
      while (!ifc.pronto && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      if (!ifc.pronto) begin
         falha("partida_sem_fim");
         aplicaReset();
      end else begin
         repeat ($urandom_range(1, 5)) @(negedge clock);
         verifica("flags_mantidos", 32'({ifc.pronto, ifc.ganhou, ifc.perdeu, ifc.timeout}), 32'({1'b1, codigo}));
         verifica("estado_final", 32'(ifc.db_estado), 32'(estado));
      end
   endtask

   // player: presses the planned note after the planned delay in each wait
   // state, and fires stray presses elsewhere that must be ignored
   initial begin
      jogada_t atual;
      bit      esperando;
      int      espera;
      esperando        = 1'b0;
      espera           = 0;
      atual.ehTimeout  = 1'b1;
      atual.atraso     = 0;
      atual.nota       = 4'd0;
      botoes           = 4'd0;
      ifc.jogada_feita = 1'b0;
      forever begin
         @(negedge clock);
         ifc.jogada_feita = 1'b0;
         if (!reset) begin
            esperando       = 1'b0;
            espera          = 0;
            atual.ehTimeout = 1'b1;
         end else if (ifc.contaTempo) begin
            if (!esperando) begin
               esperando = 1'b1;
               espera    = 0;
               if (filaJogadas.size() > 0) atual = filaJogadas.pop_front();
               else atual.ehTimeout = 1'b1;
            end else begin
               espera++;
            end
            if (!atual.ehTimeout && espera == atual.atraso) begin
               botoes           = atual.nota;
               ifc.jogada_feita = 1'b1;
               atual.ehTimeout  = 1'b1;
            end
         end else begin
            esperando = 1'b0;
            if ($urandom_range(0, 7) == 0) ifc.jogada_feita = 1'b1;
         end
      end
   end

   // monitor: checks every shown note, gravaM width, and each game outcome
   initial begin
      int         mostradas, gravacoes, largura;
      bit         prontoAnt;
      logic [3:0] esperada;
      resultado_t res;
      mostradas = 0;
      gravacoes = 0;
      largura   = 0;
      prontoAnt = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            mostradas = 0;
            gravacoes = 0;
            largura   = 0;
            prontoAnt = 1'b0;
         end else begin
            if (ifc.ativa_leds_mem && ifc.fimTF) begin
               mostradas++;
               if (filaMostra.size() == 0) begin
                  falha("nota_mostrada_extra");
               end else begin
                  esperada = filaMostra.pop_front();
                  verifica("nota_mostrada", 32'(notaEm(dpC)), 32'(esperada));
               end
            end
            if (ifc.gravaM) begin
               largura++;
               if (largura == 1) gravacoes++;
            end else if (largura != 0) begin
               verifica("largura_gravaM", 32'(largura), 32'd1);
               largura = 0;
            end
            if (ifc.pronto && !prontoAnt) begin
               if (filaResultados.size() == 0) begin
                  falha("resultado_inesperado");
               end else begin
                  res = filaResultados.pop_front();
                  verifica("resultado_flags", 32'({ifc.ganhou, ifc.perdeu, ifc.timeout}), 32'(res.codigo));
                  verifica("resultado_estado", 32'(ifc.db_estado), 32'(res.estado));
                  verifica("notas_mostradas", 32'(mostradas), 32'(res.mostras));
                  verifica("notas_gravadas", 32'(gravacoes), 32'(res.gravas));
               end
               mostradas = 0;
               gravacoes = 0;
            end
            prontoAnt = ifc.pronto;
         end
      end
   end

   // stimulus
   initial begin
      logic [2:0] codigo;
      logic [4:0] estado;
      int n;
      reset       = 1'b0;
      ifc.iniciar = 1'b0;
      nota0       = 4'd0;
      limite      = 4'd0;
      repeat (3) @(negedge clock);
      verifica("reset_estado", 32'(ifc.db_estado), 32'h00);
      verifica("reset_saidas", 32'(ctrlVec), 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      verifica("ocioso_estado", 32'(ifc.db_estado), 32'h00);

      // reset asserted in the middle of a feedback phase
      planGame(4, codigo, estado);
      iniciaPartida();
      n = 0;
      while (!ifc.ativa_leds_jog && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      verifica("alcanca_feedback", 32'(ifc.db_estado), 32'h08);
      #3 reset = 1'b0;
      #1;
      verifica("reset_async_estado", 32'(ifc.db_estado), 32'h00);
      verifica("reset_async_saidas", 32'(ctrlVec), 32'h0);
      limpaFilas();
      repeat (2) @(negedge clock);
      reset = 1'b1;

      jogarPartida(1);
      jogarPartida(2);
      jogarPartida(3);
      jogarPartida(4);
      for (int g = 0; g < 24; g++) jogarPartida(0);

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore FSM that sequences the piano-game datapath (`fluxo_dados`) for the "follow-me" game.
- Each round: plays the stored sequence up to the current round (LED plus buzzer), then checks the player's notes one by one with a per-note timeout.
- Optionally records one new player note per round, then ends in win, error or timeout.
- Sits beside the datapath in the top level; all datapath control inputs are driven from here, all condition outputs are consumed here.

Parameters:
- GRAVA_NOVA, 1, 1 = player appends a new note to memory after each won round; 0 = memory is preloaded and no write occurs.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- iniciar  input  1  start/restart request, level-sampled.
- jogada_feita  input  1  one-cycle pulse when a button is pressed.
- jogada_correta  input  1  memory word equals registered play.
- enderecoIgualRodada  input  1  address counter equals round counter.
- fimCR  input  1  round counter at 15.
- fimTF  input  1  0.5 s feedback timer terminal.
- fimTempo  input  1  5 s timeout terminal.
- zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTempo, contaTempo, zeraTM, contaTM, ativa_leds_mem, ativa_leds_jog, toca, gravaM  output  1 each  datapath controls.
- pronto  output  1  game finished.
- ganhou  output  1  win.
- perdeu  output  1  wrong note.
- timeout  output  1  no play within 5 s.
- db_estado  output  5  current state code.

Behaviour:
- State register only; all outputs decode combinationally from state (Moore). Any output not listed for a state is 0.
- Reset low: state = inicial (00h) immediately, all outputs 0, including mid-round. Unused codes go to inicial on the next clock.

States and transitions:
- 00h inicial: no outputs. iniciar=1 → 01h.
- 01h preparacao: zeraR, zeraC, zeraCR, zeraTempo, zeraTM. → 02h.
- 02h mostra: ativa_leds_mem, toca, contaTM. fimTF → 03h.
- 03h avalia_mostra: zeraTM. enderecoIgualRodada → 05h, else → 04h.
- 04h incrementa_mostra: contaC. → 02h.
- 05h inicia_jogada: zeraC, zeraTempo, zeraTM. → 06h.
- 06h espera_jogada: contaTempo. jogada_feita → 07h, else fimTempo → 0Eh. If both occur in the same cycle, jogada_feita wins.
- 07h registra: registraR. → 08h.
- 08h feedback: ativa_leds_jog, toca, contaTM. fimTF → 09h.
- 09h compara: zeraTM. Priority order:
  - jogada_correta=0 → 0Dh.
  - enderecoIgualRodada=0 → 0Ah.
  - fimCR=1 → 0Ch.
  - otherwise → 0Bh.
- 0Ah proxima_jogada: contaC, zeraTempo. → 06h.
- 0Bh proxima_rodada: contaCR, contaC, zeraTempo. GRAVA_NOVA=1 → 10h, else → 11h.
- 10h espera_nova: contaTempo. jogada_feita → 12h, else fimTempo → 0Eh.
- 12h grava: registraR, gravaM (exactly one cycle). → 13h.
- 13h feedback_nova: ativa_leds_jog, toca, contaTM. fimTF → 11h.
- 11h reinicia_mostra: zeraC, zeraTM, zeraTempo. → 02h.
- 0Ch ganhou: pronto, ganhou.
- 0Dh errou: pronto, perdeu.
- 0Eh timeout: pronto, perdeu, timeout.
- From 0Ch, 0Dh, 0Eh: iniciar=1 → 01h; while low, hold and keep flags asserted.

Timing and counting rules:
- Latency from a jogada_feita pulse to the compare decision: 1 cycle (registra) + TEMPO_FEEDBACK cycles (feedback) + 1 cycle (compara).
- Each stored note is shown for one full fimTF period; exactly N+1 notes are shown in round N.
- contaC and contaCR are asserted for exactly one cycle per visit, so counters never double-step.
- jogada_feita pulses arriving outside 06h and 10h are ignored.

Test Plan:
- Reset release, iniciar=1 for one cycle → 00h→01h→02h; zeraC/zeraCR/zeraR high exactly in 01h; toca=ativa_leds_mem=1 until fimTF.
- Round 0, memory[0]=4'b0010, press 0010 → 07h, 08h, then compara → 0Bh; contaCR one cycle; with GRAVA_NOVA=1 reaches 10h; press 0100 → gravaM high exactly one cycle.
- Round 1: 2 notes shown (03h visited twice, 04h once); press 0010 then 1000 against stored 0100 → 0Dh, perdeu=pronto=1, held until iniciar.
- In 06h hold no button, force fimTempo → 0Eh with timeout=perdeu=1; jogada_feita and fimTempo in the same cycle → 07h instead.
- Force fimCR=1 with correct last note → 0Ch, ganhou=1; then iniciar=1 → 01h with flags cleared.
- Drive reset low while in 08h → all outputs 0 and db_estado=00h before the next clock edge; release and iniciar restarts cleanly.
